// File: rtl/mul_booth_seq.sv
// Sequential signed 32x32 multiplier, radix-4 Booth recoding.
// One cycle to capture the operands, sixteen bit-pair iterations, then a
// single-cycle done pulse with the 64-bit product on hi/lo.
module mul_booth_seq (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    // Accumulator word: {A[34:0], Q[31:0], Q[-1]}. A is 35 bits so that
    // A +/- 2M can never overflow, even for M = -2^31.
    localparam int AW   = 35;
    localparam int ACCW = AW + 32 + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     m_q, m_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              capture_s;
    logic              iterate_s;
    logic              last_s;
    logic [AW-1:0]     sum_s;
    logic [ACCW-1:0]   shifted_s;

    // Booth bit-pair recoding: {Q[i+1], Q[i], Q[i-1]} selects 0, +/-M, +/-2M.
    function automatic logic [AW-1:0] booth_addend(input logic [2:0] code,
                                                   input logic [AW-1:0] m);
        logic [AW-1:0] r;
        case (code)
            3'b001, 3'b010: r = m;
            3'b011:         r = m << 1;
            3'b100:         r = {AW{1'b0}} - (m << 1);
            3'b101, 3'b110: r = {AW{1'b0}} - m;
            default:        r = {AW{1'b0}};
        endcase
        return r;
    endfunction

    assign last_s = (state_q == RUN) && (cnt_q == 4'd15);

    // FSM state register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: capture/iterate strobes and next values of busy/done.
    always_comb begin
        capture_s = 1'b0;
        iterate_s = 1'b0;
        case (state_q)
            IDLE:    capture_s = start;
            RUN:     iterate_s = 1'b1;
            default: begin
                capture_s = 1'b0;
                iterate_s = 1'b0;
            end
        endcase
        done_d = last_s;
        busy_d = capture_s | (iterate_s & ~last_s);
    end

    // One Booth step: add the selected multiple to A, then shift the whole
    // accumulator word right arithmetically by two.
    always_comb begin
        sum_s     = acc_q[ACCW-1:33] + booth_addend(acc_q[2:0], m_q);
        shifted_s = ACCW'($signed({sum_s, acc_q[32:0]}) >>> 2);
    end

    // Datapath next state: operand capture, iteration, result write-back.
    always_comb begin
        m_d   = m_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (capture_s) begin
            m_d   = {{3{multiplicand[31]}}, multiplicand};
            acc_d = {{AW{1'b0}}, multiplier, 1'b0};
            cnt_d = 4'd0;
        end else if (iterate_s) begin
            acc_d = shifted_s;
            if (last_s) begin
                cnt_d = cnt_q;
                hi_d  = shifted_s[64:33];
                lo_d  = shifted_s[32:1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath and output registers, all cleared asynchronously.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_q    <= {AW{1'b0}};
            acc_q  <= {ACCW{1'b0}};
            cnt_q  <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: directed vector table, hand-written
// corner sequences and randomized operands against a 64-bit arithmetic model.
module tb_mul_booth_seq;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[10];

    mul_booth_seq dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed 64-bit multiplication.
    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = longint'($signed(m));
        b = longint'($signed(q));
        return a * b;
    endfunction

    // Present operands with start for one cycle; returns #1 after edge E0.
    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        @(negedge clock);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clock);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Follow edges E1..E16 checking busy/done/hold, then the result in the
    // done cycle. noise scrambles inputs and start during the run; pulse_k
    // injects one start with M=2,Q=2 after edge pulse_k.
    task automatic finish_op(input logic [63:0] exp, input bit noise, input int pulse_k,
                             output int done_at);
        logic [63:0] held;
        held    = {hi, lo};
        done_at = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock);
            #1;
            if (k < 16) begin
                check("busy_run", {63'd0, busy}, 64'd1);
                check("done_run", {63'd0, done}, 64'd0);
                check("hold_run", {hi, lo}, held);
                if (noise) begin
                    start        = 1'($urandom_range(0, 1));
                    multiplicand = $urandom;
                    multiplier   = $urandom;
                end else if (k == pulse_k) begin
                    start        = 1'b1;
                    multiplicand = 32'd2;
                    multiplier   = 32'd2;
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = 1'b0;
                check("busy_done", {63'd0, busy}, 64'd0);
                check("done_pulse", {63'd0, done}, 64'd1);
                check("product", {hi, lo}, exp);
                done_at = cyc;
            end
        end
    endtask

    task automatic do_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                         input bit noise, output int done_at);
        start_op(m, q);
        finish_op(exp, noise, 0, done_at);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0:       r = 32'h8000_0000;
            1:       r = 32'h7FFF_FFFF;
            2:       r = 32'hFFFF_FFFF;
            3:       r = 32'd0;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    initial begin
        int          d_prev;
        int          d_now;
        logic [31:0] rm;
        logic [31:0] rq;

        vecs[0] = '{32'd7,         32'd3,         64'h0000_0000_0000_0015};
        vecs[1] = '{32'hFFFF_FFFB, 32'd3,         64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[7] = '{32'd1,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8] = '{32'd0,         32'h8000_0000, 64'h0000_0000_0000_0000};
        vecs[9] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

        // Reset with start held high: nothing may happen.
        clear_n      = 1'b0;
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_hold_busy", {63'd0, busy}, 64'd0);
        check("rst_hold_hilo", {hi, lo}, 64'd0);

        // Start accepted on the first edge after release: 7 * 3.
        @(negedge clock);
        clear_n      = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        finish_op(64'h15, 1'b0, 0, d_prev);

        // Directed table, back-to-back: each start lands in the done cycle.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].m, vecs[i].q, vecs[i].p, 1'b0, d_now);
            check("period17", 64'(d_now - d_prev), 64'd17);
            d_prev = d_now;
        end

        // Start pulsed mid-run is ignored: only 6*7 comes out, once.
        start_op(32'd6, 32'd7);
        finish_op(64'd42, 1'b0, 4, d_now);
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            check("no_second_done", {63'd0, done}, 64'd0);
            check("no_restart_busy", {63'd0, busy}, 64'd0);
        end
        check("hold_after_done", {hi, lo}, 64'd42);

        // Reset mid-operation clears everything at once and drops the op.
        start_op(32'd100, 32'd100);
        repeat (7) @(posedge clock);
        @(negedge clock);
        clear_n = 1'b0;
        start   = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            #1;
            check("midrst_no_done", {63'd0, done}, 64'd0);
            check("midrst_hilo_hold", {hi, lo}, 64'd0);
        end
        @(negedge clock);
        clear_n      = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        @(posedge clock);
        #1;
        start = 1'b0;
        finish_op(64'h2710, 1'b0, 0, d_prev);

        // Randomized back-to-back operations with noisy inputs during runs.
        for (int n = 0; n < 2000; n++) begin
            rm = pick_operand();
            rq = pick_operand();
            do_op(rm, rq, ref_mul(rm, rq), 1'b1, d_now);
            check("rand_period17", 64'(d_now - d_prev), 64'd17);
            d_prev = d_now;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
